// File: rtl/vga_timing_pkg.sv
// Shared raster timing sets and helpers for the VGA timing generator.
package vga_timing_pkg;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } timing_t;

  localparam timing_t VGA_640X480_H  = '{640, 16, 96, 48};
  localparam timing_t VGA_640X480_V  = '{480, 10, 2, 33};
  localparam timing_t XGA_1024X768_H = '{1024, 24, 136, 160};
  localparam timing_t XGA_1024X768_V = '{768, 3, 6, 29};

  function automatic int total(input timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Registered raster outputs from the timing generator to the pixel logic.
interface vga_timing_gen_if #(
  parameter int CNT_W = 11
);
  logic             hsync;
  logic             vsync;
  logic             de;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             line_start;
  logic             frame_start;
  logic             frame_tick;

  modport master (output hsync, vsync, de, x, y, line_start, frame_start, frame_tick);
  modport slave  (input  hsync, vsync, de, x, y, line_start, frame_start, frame_tick);
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: enabled wrapping counter plus active/sync window decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int CNT_W  = 11
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o,
  output logic             active_o,
  output logic             sync_o
);
  localparam int               TOTAL = total(timing_t'{ACTIVE, FP, SYNC, BP});
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // Window bounds compared at 32 bits so ACTIVE == 2**CNT_W cannot truncate.
  assign cnt_o    = cnt_q;
  assign wrap_o   = (cnt_q == LAST);
  assign active_o = (32'(cnt_q) < ACTIVE);
  assign sync_o   = (32'(cnt_q) >= ACTIVE + FP) && (32'(cnt_q) < ACTIVE + FP + SYNC);

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: H/V counters, registered sync/de/coords and strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_640X480_H.active,
  parameter int H_FP     = VGA_640X480_H.fp,
  parameter int H_SYNC   = VGA_640X480_H.sync,
  parameter int H_BP     = VGA_640X480_H.bp,
  parameter int V_ACTIVE = VGA_640X480_V.active,
  parameter int V_FP     = VGA_640X480_V.fp,
  parameter int V_SYNC   = VGA_640X480_V.sync,
  parameter int V_BP     = VGA_640X480_V.bp,
  parameter bit SYNC_POL = 1'b0,
  parameter int CNT_W    = 11
) (
  input  logic             pixclk,
  input  logic             rst_n,
  input  logic             pix_ce,
  vga_timing_gen_if.master vid
);
  localparam int H_TOTAL = total(timing_t'{H_ACTIVE, H_FP, H_SYNC, H_BP});
  localparam int V_TOTAL = total(timing_t'{V_ACTIVE, V_FP, V_SYNC, V_BP});
  localparam logic [CNT_W-1:0] V_TICK = CNT_W'(V_ACTIVE);

  if (H_TOTAL > 2**CNT_W || V_TOTAL > 2**CNT_W || H_SYNC < 1 || V_SYNC < 1) begin : g_cfg_err
    $error("vga_timing_gen: CNT_W too small for totals or sync width < 1");
  end

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic h_wrap, h_act, h_sync, v_wrap, v_act, v_sync;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CNT_W(CNT_W)
  ) u_h (
    .clk_i(pixclk), .rst_n_i(rst_n), .en_i(pix_ce),
    .cnt_o(h_cnt), .wrap_o(h_wrap), .active_o(h_act), .sync_o(h_sync)
  );

  // Lines advance only on the last pixel, so vsync edges land on h==0.
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CNT_W(CNT_W)
  ) u_v (
    .clk_i(pixclk), .rst_n_i(rst_n), .en_i(pix_ce & h_wrap),
    .cnt_o(v_cnt), .wrap_o(v_wrap), .active_o(v_act), .sync_o(v_sync)
  );

  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic ls_q, ls_d, fs_q, fs_d, ft_q, ft_d;

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    de_d = de_q;
    hs_d = hs_q;
    vs_d = vs_q;
    if (pix_ce) begin
      x_d  = h_cnt;
      y_d  = v_cnt;
      de_d = h_act & v_act;
      hs_d = h_sync ? SYNC_POL : ~SYNC_POL;
      vs_d = v_sync ? SYNC_POL : ~SYNC_POL;
    end
    // Strobes reload every edge, so a pix_ce=0 edge clears them.
    ls_d = pix_ce & (h_cnt == '0);
    fs_d = ls_d & (v_cnt == '0);
    ft_d = ls_d & (v_cnt == V_TICK);
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= '0;
      y_q  <= '0;
      de_q <= 1'b0;
      hs_q <= ~SYNC_POL;
      vs_q <= ~SYNC_POL;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
      ft_q <= 1'b0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      de_q <= de_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
      ft_q <= ft_d;
    end
  end

  assign vid.x           = x_q;
  assign vid.y           = y_q;
  assign vid.de          = de_q;
  assign vid.hsync       = hs_q;
  assign vid.vsync       = vs_q;
  assign vid.line_start  = ls_q;
  assign vid.frame_start = fs_q;
  assign vid.frame_tick  = ft_q;

  a_v_wrap : assert property (@(posedge pixclk) disable iff (!rst_n)
    (pix_ce && h_wrap && v_wrap) |=> (v_cnt == '0));

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: 640x480 line timing, pix_ce hold, async reset, tiny-raster table.
module tb_vga_timing_gen;

  logic pixclk = 1'b0;
  logic rst_a, rst_b, ce_a, ce_b;
  always #5 pixclk = ~pixclk;

  vga_timing_gen_if #(.CNT_W(11)) va ();
  vga_timing_gen_if #(.CNT_W(3))  vb ();

  vga_timing_gen u_a (.pixclk(pixclk), .rst_n(rst_a), .pix_ce(ce_a), .vid(va));

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .CNT_W(3)
  ) u_b (.pixclk(pixclk), .rst_n(rst_b), .pix_ce(ce_b), .vid(vb));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pixclk);
    @(negedge pixclk);
  endtask

  typedef struct {
    logic ce;
    int   x, y;
    logic de, hs, vs, ls, fs, ft;
  } vec_t;

  vec_t tbl[28];

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, de_n, hs_n, hs_x, ls_after, hold_err, prev_x, maxx, maxy, vs_n, ft_n, ft_x, ft_y, vs_x, vs_y;
    logic prev_de, prev_hs;

    //          ce  x  y  de  hs  vs  ls  fs  ft
    tbl[0]  = '{1, 0, 0, 1, 1, 1, 1, 1, 0};
    tbl[1]  = '{1, 1, 0, 1, 1, 1, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 1, 1, 1, 0, 0, 0};
    tbl[3]  = '{1, 2, 0, 1, 1, 1, 0, 0, 0};
    tbl[4]  = '{1, 3, 0, 1, 1, 1, 0, 0, 0};
    tbl[5]  = '{1, 4, 0, 0, 1, 1, 0, 0, 0};
    tbl[6]  = '{1, 5, 0, 0, 0, 1, 0, 0, 0};
    tbl[7]  = '{0, 5, 0, 0, 0, 1, 0, 0, 0};
    tbl[8]  = '{1, 6, 0, 0, 1, 1, 0, 0, 0};
    tbl[9]  = '{1, 0, 1, 1, 1, 1, 1, 0, 0};
    tbl[10] = '{0, 0, 1, 1, 1, 1, 0, 0, 0};
    tbl[11] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
    tbl[12] = '{1, 2, 1, 1, 1, 1, 0, 0, 0};
    tbl[13] = '{1, 3, 1, 1, 1, 1, 0, 0, 0};
    tbl[14] = '{1, 4, 1, 0, 1, 1, 0, 0, 0};
    tbl[15] = '{1, 5, 1, 0, 0, 1, 0, 0, 0};
    tbl[16] = '{1, 6, 1, 0, 1, 1, 0, 0, 0};
    tbl[17] = '{1, 0, 2, 0, 1, 1, 1, 0, 1};
    tbl[18] = '{0, 0, 2, 0, 1, 1, 0, 0, 0};
    tbl[19] = '{1, 1, 2, 0, 1, 1, 0, 0, 0};
    tbl[20] = '{1, 2, 2, 0, 1, 1, 0, 0, 0};
    tbl[21] = '{1, 3, 2, 0, 1, 1, 0, 0, 0};
    tbl[22] = '{1, 4, 2, 0, 1, 1, 0, 0, 0};
    tbl[23] = '{1, 5, 2, 0, 0, 1, 0, 0, 0};
    tbl[24] = '{1, 6, 2, 0, 1, 1, 0, 0, 0};
    tbl[25] = '{1, 0, 3, 0, 1, 0, 1, 0, 0};
    tbl[26] = '{1, 1, 3, 0, 1, 0, 0, 0, 0};
    tbl[27] = '{1, 2, 3, 0, 1, 0, 0, 0, 0};

    rst_a = 1'b0; rst_b = 1'b0; ce_a = 1'b1; ce_b = 1'b0;

    // Reset held with pix_ce=1
    repeat (10) step();
    chk("rst_hsync", va.hsync, 1);
    chk("rst_vsync", va.vsync, 1);
    chk("rst_de", va.de, 0);
    chk("rst_x", va.x, 0);
    chk("rst_y", va.y, 0);
    chk("rst_ls", va.line_start, 0);
    chk("rst_fs", va.frame_start, 0);
    chk("rst_ft", va.frame_tick, 0);

    rst_a = 1'b1;
    step();
    chk("first_x", va.x, 0);
    chk("first_y", va.y, 0);
    chk("first_de", va.de, 1);
    chk("first_ls", va.line_start, 1);
    chk("first_fs", va.frame_start, 1);
    chk("first_ft", va.frame_tick, 0);

    // One full line at one pixel per clock
    n = 0; de_n = 0; hs_n = 0; hs_x = -1;
    do begin
      step(); n++;
      if (va.de) de_n++;
      if (!va.hsync) begin
        if (hs_n == 0) hs_x = va.x;
        hs_n++;
      end
    end while (!va.line_start && n < 2000);
    chk("line_period", n, 800);
    chk("de_per_line", de_n, 640);
    chk("hsync_width", hs_n, 96);
    chk("hsync_start_x", hs_x, 656);
    chk("vsync_idle", va.vsync, 1);

    // pix_ce alternating 0,1: period doubles, levels hold on ce=0 edges
    n = 0; ls_after = -1; hold_err = 0;
    do begin
      ce_a = n[0];
      prev_x = int'(va.x); prev_de = va.de; prev_hs = va.hsync;
      step(); n++;
      if (n == 1) ls_after = int'(va.line_start);
      if (!ce_a && (int'(va.x) != prev_x || va.de != prev_de || va.hsync != prev_hs)) hold_err++;
    end while (!va.line_start && n < 4000);
    chk("line_period_ce", n, 1600);
    chk("ls_clear_on_ce0", ls_after, 0);
    chk("hold_on_ce0", hold_err, 0);
    chk("line2_y", va.y, 2);

    // Async reset mid-line, no clock edge needed
    ce_a = 1'b1; n = 0;
    while (va.x != 11'd300 && n < 2000) begin step(); n++; end
    chk("seek_x300", va.x, 300);
    #2 rst_a = 1'b0;
    #1;
    chk("async_x", va.x, 0);
    chk("async_y", va.y, 0);
    chk("async_de", va.de, 0);
    chk("async_hsync", va.hsync, 1);
    @(negedge pixclk);
    ce_a = 1'b0;
    step();
    rst_a = 1'b1;
    step();
    chk("post_rst_ce0_fs", va.frame_start, 0);
    chk("post_rst_ce0_x", va.x, 0);
    ce_a = 1'b1;
    step();
    chk("post_rst_fs", va.frame_start, 1);
    chk("post_rst_ls", va.line_start, 1);
    chk("post_rst_x", va.x, 0);
    chk("post_rst_y", va.y, 0);

    // Tiny raster 7x5 table
    for (int i = 0; i < 28; i++) begin
      ce_b = tbl[i].ce;
      if (i == 0) rst_b = 1'b1;
      step();
      chk($sformatf("t%0d_x", i), vb.x, tbl[i].x);
      chk($sformatf("t%0d_y", i), vb.y, tbl[i].y);
      chk($sformatf("t%0d_de", i), vb.de, tbl[i].de);
      chk($sformatf("t%0d_hs", i), vb.hsync, tbl[i].hs);
      chk($sformatf("t%0d_vs", i), vb.vsync, tbl[i].vs);
      chk($sformatf("t%0d_ls", i), vb.line_start, tbl[i].ls);
      chk($sformatf("t%0d_fs", i), vb.frame_start, tbl[i].fs);
      chk($sformatf("t%0d_ft", i), vb.frame_tick, tbl[i].ft);
    end

    // Tiny raster: full frame between frame_start strobes
    ce_b = 1'b1; n = 0;
    do begin step(); n++; end while (!vb.frame_start && n < 100);
    chk("seek_fs_b", vb.frame_start, 1);
    n = 0; maxx = 0; maxy = 0; vs_n = 0; ft_n = 0; ft_x = -1; ft_y = -1; vs_x = -1; vs_y = -1;
    do begin
      step(); n++;
      if (int'(vb.x) > maxx) maxx = int'(vb.x);
      if (int'(vb.y) > maxy) maxy = int'(vb.y);
      if (!vb.vsync) begin
        if (vs_n == 0) begin vs_x = int'(vb.x); vs_y = int'(vb.y); end
        vs_n++;
      end
      if (vb.frame_tick) begin ft_n++; ft_x = int'(vb.x); ft_y = int'(vb.y); end
    end while (!vb.frame_start && n < 200);
    chk("frame_period_b", n, 35);
    chk("max_x_b", maxx, 6);
    chk("max_y_b", maxy, 4);
    chk("vsync_width_b", vs_n, 7);
    chk("vsync_start_x_b", vs_x, 0);
    chk("vsync_start_y_b", vs_y, 3);
    chk("ft_count_b", ft_n, 1);
    chk("ft_x_b", ft_x, 0);
    chk("ft_y_b", ft_y, 2);
    chk("fs_ls_coincide_b", vb.line_start, 1);
    chk("fs_ft_apart_b", vb.frame_tick, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
